pipelined_cla_addsub: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Operands are split into BLOCK-bit lookahead slices. Each pipeline stage resolves one slice and registers the carry into the next stage.
- Valid/ready handshake on both sides; full throughput of one operation per cycle.
- Returns sum plus signed overflow, carry-out and zero flags.

---
 rtl/pipelined_cla_addsub_pkg.sv | 19 +
 rtl/pipelined_cla_addsub_cla_slice.sv | 46 ++++
 rtl/pipelined_cla_addsub.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared ALU definitions for the pipelined carry-lookahead adder/subtractor.
// Holds default geometry, the add/sub opcode and the per-stage control record.
package pipelined_cla_addsub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control half of a stage record; partial sum and remaining operands
    // are sized per stage and live beside it in the stage's generate scope.
    typedef struct packed {
        logic valid;
        logic carry;
        logic zero;
    } stage_ctl_t;

endpackage

// File: rtl/pipelined_cla_addsub_cla_slice.sv
// BLOCK-bit carry-lookahead slice: every carry is a flat generate/propagate
// sum of products, so nothing ripples across the slice.
module cla_slice
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             cmsb,
    output logic             zero
);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             term;
    logic             pchain;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c      = '0;
        term   = 1'b0;
        pchain = 1'b1;
        c[0]   = cin;
        for (int i = 1; i <= BLOCK; i++) begin
            term   = 1'b0;
            pchain = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                term   = term | (g[j] & pchain);
                pchain = pchain & p[j];
            end
            c[i] = term | (cin & pchain);
        end
    end

    assign sum  = p ^ c[BLOCK-1:0];
    assign cout = c[BLOCK];
    assign cmsb = c[BLOCK-1];
    assign zero = ~|sum;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor: one BLOCK-bit slice resolved per stage,
// carry registered between stages, valid/ready with collapsing bubbles.
module pipelined_cla_addsub
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_cout,
    output logic             out_zero
);
    localparam int NSTAGE = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0) begin : g_bad_width
        $fatal(1, "pipelined_cla_addsub: WIDTH %0d is not a multiple of BLOCK %0d", WIDTH, BLOCK);
    end

    logic [NSTAGE-1:0] vld;
    logic [NSTAGE-1:0] load;

    // Ready chain runs combinationally from out_ready back to stage 0.
    always_comb begin
        load           = '0;
        load[NSTAGE-1] = !vld[NSTAGE-1] || out_ready;
        for (int k = NSTAGE - 2; k >= 0; k--)
            load[k] = !vld[k] || load[k+1];
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int IW = WIDTH - k * BLOCK;

        logic [IW-1:0]          a_in;
        logic [IW-1:0]          b_in;
        logic                   cin;
        logic                   zero_in;
        logic                   valid_in;
        logic [BLOCK-1:0]       s;
        logic                   s_cout;
        logic                   s_cmsb;
        logic                   s_zero;
        logic [(k+1)*BLOCK-1:0] sum_nx;
        logic [(k+1)*BLOCK-1:0] sum_r;
        stage_ctl_t             ctl_r;

        if (k == 0) begin : g_entry
            // B is inverted once here; later stages carry it already inverted.
            assign a_in     = in_a;
            assign b_in     = in_b ^ {WIDTH{in_sub == OP_SUB}};
            assign cin      = (in_sub == OP_SUB);
            assign zero_in  = 1'b1;
            assign valid_in = in_valid;
            assign sum_nx   = s;
        end else begin : g_chain
            assign a_in     = g_stage[k-1].g_rem.a_r;
            assign b_in     = g_stage[k-1].g_rem.b_r;
            assign cin      = g_stage[k-1].ctl_r.carry;
            assign zero_in  = g_stage[k-1].ctl_r.zero;
            assign valid_in = g_stage[k-1].ctl_r.valid;
            assign sum_nx   = {s, g_stage[k-1].sum_r};
        end

        cla_slice #(.BLOCK(BLOCK)) u_slice (
            .a    (a_in[BLOCK-1:0]),
            .b    (b_in[BLOCK-1:0]),
            .cin  (cin),
            .sum  (s),
            .cout (s_cout),
            .cmsb (s_cmsb),
            .zero (s_zero)
        );

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                ctl_r <= '{valid: 1'b0, carry: 1'b0, zero: 1'b1};
                sum_r <= '0;
            end else if (load[k]) begin
                ctl_r <= '{valid: valid_in, carry: s_cout, zero: zero_in & s_zero};
                sum_r <= sum_nx;
            end
        end

        assign vld[k] = ctl_r.valid;

        if (k < NSTAGE - 1) begin : g_rem
            logic [IW-BLOCK-1:0] a_r;
            logic [IW-BLOCK-1:0] b_r;
            logic                unused_cmsb;

            // Carry into the MSB only matters in the top slice.
            assign unused_cmsb = s_cmsb;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (load[k]) begin
                    a_r <= a_in[IW-1:BLOCK];
                    b_r <= b_in[IW-1:BLOCK];
                end
            end
        end else begin : g_last
            logic ovf_r;

            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    ovf_r <= 1'b0;
                else if (load[k])
                    ovf_r <= s_cmsb ^ s_cout;
            end
        end
    end

    assign out_valid = vld[NSTAGE-1];
    assign out_sum   = g_stage[NSTAGE-1].sum_r;
    assign out_cout  = g_stage[NSTAGE-1].ctl_r.carry;
    assign out_zero  = g_stage[NSTAGE-1].ctl_r.zero;
    assign out_ovf   = g_stage[NSTAGE-1].g_last.ovf_r;

endmodule
